mealy_table_fsm: RTL and testbench

- Table-programmable Mealy state machine.
- Successor to the lab's fixed 6-state, 1-bit-in/1-bit-out Mealy machine.
- Generalised in state count, input width and output width. The transition/output table is loaded at run time through a config port, so the hard-coded case logic becomes data.
- Sits between stimulus logic (switches/debouncers) and output logic (LEDs/7-seg). Adds enable, synchronous clear, illegal-state recovery and an optional registered output.

---
 rtl/mealy_table_fsm_if.sv | 26 ++
 rtl/mealy_table_fsm.sv | 92 +++++++++
 tb/tb_mealy_table_fsm.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mealy_table_fsm_if.sv
// Configuration port for mealy_table_fsm: one table-write strobe and a combinational table read.
// cfg_we acts as a valid that is always accepted on the edge it is high, so there is no ready.
interface mealy_table_fsm_if #(
  parameter int STATE_W = 3,
  parameter int IN_W    = 1,
  parameter int OUT_W   = 1
);
  logic                     cfg_we;
  logic [STATE_W+IN_W-1:0]  cfg_addr;
  logic [STATE_W+OUT_W-1:0] cfg_wdata;
  logic [STATE_W+OUT_W-1:0] cfg_rdata;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_rdata
  );
endinterface

// File: rtl/mealy_table_fsm.sv
// Table-programmable Mealy machine: {next_state, out} looked up from a flop table indexed by {state, in}.
// Adds enable, synchronous clear, sticky illegal-state recovery and an optional registered output.
module mealy_table_fsm #(
  parameter int STATE_W    = 3,
  parameter int IN_W       = 1,
  parameter int OUT_W      = 1,
  parameter int NUM_STATES = 6,
  parameter bit REG_OUT    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [IN_W-1:0]    in,
  output logic [OUT_W-1:0]   out,
  output logic [STATE_W-1:0] state,
  output logic               err,
  mealy_table_fsm_if.slave   cfg
);

  localparam int ADDR_W  = STATE_W + IN_W;
  localparam int ENTRY_W = STATE_W + OUT_W;
  localparam int DEPTH   = 1 << ADDR_W;
  // One extra bit so NUM_STATES == 2**STATE_W still compares correctly.
  localparam logic [STATE_W:0] NUM_STATES_W = (STATE_W+1)'(NUM_STATES);

  logic [ENTRY_W-1:0] tbl_q [DEPTH];
  logic [ENTRY_W-1:0] tbl_d [DEPTH];
  logic [STATE_W-1:0] state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               err_q, err_d;

  logic [ENTRY_W-1:0] entry;
  logic [STATE_W-1:0] e_next;
  logic [OUT_W-1:0]   e_out;
  logic               e_legal;

  assign entry   = tbl_q[{state_q, in}];
  assign e_next  = entry[ENTRY_W-1:OUT_W];
  assign e_out   = entry[OUT_W-1:0];
  assign e_legal = ({1'b0, e_next} < NUM_STATES_W);

  // Lookup reads tbl_q, so a write to the entry in use only takes effect next cycle.
  always_comb begin
    tbl_d = tbl_q;
    if (cfg.cfg_we) begin
      tbl_d[cfg.cfg_addr] = cfg.cfg_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    if (sync_clr) begin
      state_d = '0;
      out_d   = '0;
    end else if (en) begin
      out_d = e_out;
      if (e_legal) begin
        state_d = e_next;
      end else begin
        state_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign out           = REG_OUT ? out_q : e_out;
  assign state         = state_q;
  assign err           = err_q;
  assign cfg.cfg_rdata = tbl_q[cfg.cfg_addr];

endmodule

// File: tb/tb_mealy_table_fsm.sv
// Bench for mealy_table_fsm: a combinational-output and a registered-output instance share stimulus
// and are checked against directed vectors, hand sequences and a table-level reference model.
module tb_mealy_table_fsm;

  localparam int SW = 3;
  localparam int IW = 1;
  localparam int OW = 1;
  localparam int NS = 6;
  localparam int AW = SW + IW;
  localparam int EW = SW + OW;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          en, sync_clr;
  logic [IW-1:0] in_s;
  logic [OW-1:0] out0, out1;
  logic [SW-1:0] st0, st1;
  logic          err0, err1;

  mealy_table_fsm_if #(.STATE_W(SW), .IN_W(IW), .OUT_W(OW)) cfg0 ();
  mealy_table_fsm_if #(.STATE_W(SW), .IN_W(IW), .OUT_W(OW)) cfg1 ();

  mealy_table_fsm #(.STATE_W(SW), .IN_W(IW), .OUT_W(OW), .NUM_STATES(NS), .REG_OUT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .in(in_s),
    .out(out0), .state(st0), .err(err0), .cfg(cfg0.slave)
  );

  mealy_table_fsm #(.STATE_W(SW), .IN_W(IW), .OUT_W(OW), .NUM_STATES(NS), .REG_OUT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .in(in_s),
    .out(out1), .state(st1), .err(err1), .cfg(cfg1.slave)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  int m_next [DEPTH];
  int m_out  [DEPTH];
  int m_state;
  int m_err;
  int m_rout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_next[i] = 0;
      m_out[i]  = 0;
    end
    m_state = 0;
    m_err   = 0;
    m_rout  = 0;
  endtask

  function automatic int m_entry(input int a);
    return m_next[a] * (1 << OW) + m_out[a];
  endfunction

  task automatic check_model(input string tag, input int a);
    int idx;
    idx = m_state * (1 << IW) + int'(in_s);
    chk({tag, "_out_comb"}, 32'(out0), 32'(m_out[idx]));
    chk({tag, "_out_reg"},  32'(out1), 32'(m_rout));
    chk({tag, "_state"},    32'(st0),  32'(m_state));
    chk({tag, "_state_r"},  32'(st1),  32'(m_state));
    chk({tag, "_err"},      32'(err0), 32'(m_err));
    chk({tag, "_err_r"},    32'(err1), 32'(m_err));
    chk({tag, "_rdata"},    32'(cfg0.cfg_rdata), 32'(m_entry(a)));
    chk({tag, "_rdata_r"},  32'(cfg1.cfg_rdata), 32'(m_entry(a)));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic e, input logic c, input logic [IW-1:0] i,
                       input logic we, input logic [AW-1:0] a, input logic [EW-1:0] wd);
    en = e; sync_clr = c; in_s = i;
    cfg0.cfg_we = we; cfg0.cfg_addr = a; cfg0.cfg_wdata = wd;
    cfg1.cfg_we = we; cfg1.cfg_addr = a; cfg1.cfg_wdata = wd;
  endtask

  // One clock: drive at negedge, check pre-edge outputs, advance model on posedge, check again.
  task automatic step(input logic e, input logic c, input logic [IW-1:0] i,
                      input logic we, input logic [AW-1:0] a, input logic [EW-1:0] wd,
                      output logic [OW-1:0] out_before, output logic [SW-1:0] state_after,
                      output logic [OW-1:0] rout_after);
    int idx;
    @(negedge clk);
    drive(e, c, i, we, a, wd);
    #1;
    check_model("pre", int'(a));
    out_before = out0;
    idx = m_state * (1 << IW) + int'(i);
    @(posedge clk);
    if (c) begin
      m_state = 0;
      m_rout  = 0;
    end else if (e) begin
      m_rout = m_out[idx];
      if (m_next[idx] >= NS) begin
        m_state = 0;
        m_err   = 1;
      end else begin
        m_state = m_next[idx];
      end
    end
    if (we) begin
      m_next[int'(a)] = int'(wd) >> OW;
      m_out[int'(a)]  = int'(wd) & ((1 << OW) - 1);
    end
    #1;
    check_model("post", int'(a));
    state_after = st0;
    rout_after  = out1;
  endtask

  typedef struct {
    logic          en;
    logic          clr;
    logic [IW-1:0] in;
    logic          we;
    logic [AW-1:0] addr;
    logic [EW-1:0] wd;
    logic [OW-1:0] exp_out;
    logic [SW-1:0] exp_state;
    logic [OW-1:0] exp_rout;
  } vec_t;

  vec_t vecs [8];

  logic [OW-1:0] ob, ro;
  logic [SW-1:0] sa;

  initial begin
    // Program {0,1}->{2,1}, {2,0}->{5,1}, {5,0}->{3,0}, {3,0}->{3,1}, then run in=1,0,0,0.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  4'd5,  1'b0, 3'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  4'd11, 1'b0, 3'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 4'd6,  1'b0, 3'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd6,  4'd7,  1'b0, 3'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 3'd2, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 3'd5, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 3'd3, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 3'd3, 1'b1};

    // Reset held with in=1 and a write pending: the write must be lost.
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(st0), 32'd0);
    chk("rst_out",   32'(out0), 32'd0);
    chk("rst_out_r", 32'(out1), 32'd0);
    chk("rst_err",   32'(err0), 32'd0);
    chk("rst_rdata", 32'(cfg0.cfg_rdata), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, ob, sa, ro);
    chk("rst_release_state", 32'(sa), 32'd0);

    // Program and run from the vector table.
    for (int k = 0; k < 8; k++) begin
      step(vecs[k].en, vecs[k].clr, vecs[k].in, vecs[k].we, vecs[k].addr, vecs[k].wd, ob, sa, ro);
      chk($sformatf("vec%0d_out", k),   32'(ob), 32'(vecs[k].exp_out));
      chk($sformatf("vec%0d_state", k), 32'(sa), 32'(vecs[k].exp_state));
      chk($sformatf("vec%0d_rout", k),  32'(ro), 32'(vecs[k].exp_rout));
    end

    // Illegal next state sets err and forces state 0; err survives sync_clr.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, ob, sa, ro);
    chk("clr_rout", 32'(ro), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd14, ob, sa, ro);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, ob, sa, ro);
    chk("illegal_state", 32'(sa), 32'd0);
    chk("illegal_err", 32'(err0), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, ob, sa, ro);
    chk("illegal_err_sticky", 32'(err0), 32'd1);

    // Collision: restore {0,1}->{2,1}, then overwrite it while it is being used.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd5, ob, sa, ro);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd8, ob, sa, ro);
    chk("collide_old_state", 32'(sa), 32'd2);
    chk("collide_old_out", 32'(ob), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, ob, sa, ro);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, ob, sa, ro);
    chk("collide_new_state", 32'(sa), 32'd4);
    chk("collide_new_out", 32'(ob), 32'd0);

    // Hold with en=0, then sync_clr beats en.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'(k), 1'b0, 4'd0, 4'd0, ob, sa, ro);
      chk($sformatf("hold%0d_state", k), 32'(sa), 32'd4);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, ob, sa, ro);
    chk("clr_over_en_state", 32'(sa), 32'd0);

    // Asynchronous reset between edges.
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, ob, sa, ro);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(st0), 32'd0);
    chk("arst_err",   32'(err0), 32'd0);
    chk("arst_out_r", 32'(out1), 32'd0);
    chk("arst_rdata", 32'(cfg0.cfg_rdata), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the model; next states mostly legal, sometimes 6 or 7.
    for (int k = 0; k < 400; k++) begin
      logic [SW-1:0] nx;
      nx = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(6, 7)) : SW'($urandom_range(0, 5));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), IW'($urandom),
           1'($urandom_range(0, 2) == 0), AW'($urandom), {nx, OW'($urandom)}, ob, sa, ro);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
